// File: rtl/axiom_apb_mem_completer.sv
// APB4 completer backed by a word-addressed register memory with byte strobes,
// programmable wait states and error responses (misaligned, out of range, privileged top word).
module axiom_apb_mem_completer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pwstrb,
    input  logic [2:0]              pprot,
    input  logic [3:0]              cfg_wait,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    xfer_done
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned B     = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TOP   = B + IDX_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [DATA_WIDTH-1:0]   prdata_d;
    logic                    pready_d, pslverr_d, xfer_done_d;
    logic                    load_c, mem_we_c;

    logic [IDX_W-1:0]        idx_c, lat_idx;
    logic                    misalign_c, oor_c, priv_c, err_c;
    logic                    lat_write, lat_err;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [BYTES-1:0]        lat_strb;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Only pprot[0] (privileged) matters to this completer.
    logic unused_prot;
    assign unused_prot = ^pprot[2:1];

    assign idx_c = paddr[TOP-1:B];

    if (B > 0) begin : g_align
        assign misalign_c = |paddr[B-1:0];
    end else begin : g_no_align
        assign misalign_c = 1'b0;
    end

    // Any address bit above the memory span means the byte address is past the end.
    if (ADDR_WIDTH > TOP) begin : g_range
        assign oor_c = |paddr[ADDR_WIDTH-1:TOP];
    end else begin : g_no_range
        assign oor_c = 1'b0;
    end

    // The top word is a privileged-only register for writes.
    assign priv_c = pwrite && (idx_c == IDX_W'(DEPTH - 1)) && !pprot[0];
    assign err_c  = misalign_c || oor_c || priv_c;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            prdata    <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            prdata    <= prdata_d;
            pready    <= pready_d;
            pslverr   <= pslverr_d;
            xfer_done <= xfer_done_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        prdata_d    = '0;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        xfer_done_d = 1'b0;
        load_c      = 1'b0;
        mem_we_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (psel && !penable) begin
                    load_c = 1'b1;
                    if (cfg_wait == '0) begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = err_c;
                        if (!pwrite && !err_c) begin
                            prdata_d = mem[idx_c];
                        end
                    end else begin
                        cnt_d   = cfg_wait - 4'd1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (cnt == '0) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = lat_err;
                    if (!lat_write && !lat_err) begin
                        prdata_d = mem[lat_idx];
                    end
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                xfer_done_d = 1'b1;
                mem_we_c    = lat_write && !lat_err;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Setup-phase capture; the error verdict is frozen with the request.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
        end else if (load_c) begin
            lat_idx   <= idx_c;
            lat_write <= pwrite;
            lat_err   <= err_c;
            lat_wdata <= pwdata;
            lat_strb  <= pwstrb;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we_c) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (lat_strb[b]) begin
                    mem[lat_idx][b*8 +: 8] <= lat_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule
